// File: rtl/cache_writeback_buffer_pkg.sv
// Shared types for the L1 writeback (victim) buffer.
package cache_writeback_buffer_pkg;

    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2,
        FILL  = 2'd3
    } wbuf_state_t;

endpackage

// File: rtl/cache_writeback_buffer_wbuf_entry.sv
// Single buffered line: valid bit, line tag and line data.
// A load wins over a clear so a capture in the drain-complete cycle survives.
module cache_writeback_buffer_wbuf_entry #(
    parameter int unsigned TAG_WIDTH  = 12,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [TAG_WIDTH-1:0]  load_tag,
    input  logic [LINE_WIDTH-1:0] load_data,
    output logic                  valid,
    output logic [TAG_WIDTH-1:0]  tag,
    output logic [LINE_WIDTH-1:0] data
);

    // Entry storage; reset discards the buffered line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tag   <= load_tag;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_writeback_buffer.sv
// Single-entry victim buffer between the L1 data array and physical memory.
// Captures an evicted dirty line in one cycle, lets the refill go first,
// drains the line in the background and serves refills that hit the line.
module cache_writeback_buffer
    import cache_writeback_buffer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [LINE_WIDTH-1:0] wb_data,
    output logic                  wb_ack,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  fill_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  busy
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    wbuf_state_t state, state_next;

    logic                  ent_valid;
    logic [TAG_WIDTH-1:0]  ent_tag;
    logic [LINE_WIDTH-1:0] ent_data;
    logic [TAG_WIDTH-1:0]  fill_tag;
    logic [TAG_WIDTH-1:0]  wb_tag;
    logic                  hit;
    logic                  accept;
    logic                  drain_done;
    logic                  fill_done;
    logic                  hit_resp_q;
    logic                  unused_offsets;

    assign fill_tag   = fill_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign wb_tag     = wb_addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_offsets = ^{fill_addr[OFFSET_BITS-1:0], wb_addr[OFFSET_BITS-1:0]};

    assign hit        = ent_valid & (fill_tag == ent_tag);
    assign drain_done = (state == DRAIN) & pmem_resp;
    assign fill_done  = (state == FILL) & pmem_resp;

    // Capture only when empty, or when the drain retires this very edge.
    // Gated by rst so wb_ack reads 0 while reset is held.
    assign accept = wb_req & ~rst & ((state == IDLE) | drain_done);

    cache_writeback_buffer_wbuf_entry #(
        .TAG_WIDTH  (TAG_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_wbuf_entry (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .clear     (drain_done),
        .load_tag  (wb_tag),
        .load_data (wb_data),
        .valid     (ent_valid),
        .tag       (ent_tag),
        .data      (ent_data)
    );

    // Next-state selection; in HELD a pending refill beats the drain.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept)        state_next = HELD;
                else if (fill_req) state_next = FILL;
            end
            HELD: begin
                if (fill_req) begin
                    if (!hit) state_next = FILL;
                end else begin
                    state_next = DRAIN;
                end
            end
            FILL: begin
                if (pmem_resp) state_next = ent_valid ? HELD : IDLE;
            end
            DRAIN: begin
                if (pmem_resp) state_next = accept ? HELD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any pmem transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // One-cycle-latency hit response; the self-mask stops a second pulse
    // while the requester is still holding fill_req in the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hit_resp_q <= 1'b0;
        else     hit_resp_q <= (state == HELD) & fill_req & hit & ~hit_resp_q;
    end

    // Memory-side and requester-side outputs.
    always_comb begin
        pmem_address = '0;
        if (state == FILL)       pmem_address = {fill_tag, {OFFSET_BITS{1'b0}}};
        else if (state == DRAIN) pmem_address = {ent_tag, {OFFSET_BITS{1'b0}}};

        fill_data = '0;
        if (fill_done)       fill_data = pmem_rdata;
        else if (hit_resp_q) fill_data = ent_data;
    end

    assign wb_ack     = accept;
    assign pmem_read  = (state == FILL);
    assign pmem_write = (state == DRAIN);
    assign pmem_wdata = ent_data;
    assign fill_resp  = hit_resp_q | fill_done;
    assign busy       = ent_valid | (state != IDLE);

endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Directed scoreboard bench for cache_writeback_buffer.
module tb_cache_writeback_buffer;

    logic         clk;
    logic         rst;
    logic         wb_req;
    logic [15:0]  wb_addr;
    logic [127:0] wb_data;
    logic         wb_ack;
    logic         fill_req;
    logic [15:0]  fill_addr;
    logic [127:0] fill_data;
    logic         fill_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         busy;

    typedef struct {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } pmem_txn_t;

    pmem_txn_t    exp_pmem[$];
    logic [127:0] exp_fill[$];

    int checks   = 0;
    int failures = 0;

    cache_writeback_buffer #(
        .ADDR_WIDTH  (16),
        .LINE_WIDTH  (128),
        .OFFSET_BITS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_req       (wb_req),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_ack       (wb_ack),
        .fill_req     (fill_req),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .fill_resp    (fill_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an evict request and hold it until wb_ack (bounded).
    task automatic evict(input logic [15:0] a, input logic [127:0] d, input string tag);
        int n = 0;
        wb_req  = 1'b1;
        wb_addr = a;
        wb_data = d;
        #1;
        while (!wb_ack && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_wb_ack"}, 128'(wb_ack), 128'(1));
        @(negedge clk);
        wb_req = 1'b0;
        #1;
    endtask

    // Wait for a pmem request, compare it with the scoreboard, hold one
    // extra cycle to check stability, then respond.
    task automatic pmem_service(input logic [127:0] rdata, input string tag, input bit wb_at_resp);
        int n = 0;
        pmem_txn_t e;
        logic [127:0] ef;
        while (!(pmem_read || pmem_write) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_req_seen"}, 128'(pmem_read | pmem_write), 128'(1));
        check({tag, "_not_both"}, 128'(pmem_read & pmem_write), 128'(0));
        check({tag, "_sb_nonempty"}, 128'(exp_pmem.size() != 0), 128'(1));
        if (exp_pmem.size() != 0) e = exp_pmem.pop_front();
        else e = '{wr: 1'b0, addr: 16'h0, data: 128'h0};
        check({tag, "_write"}, 128'(pmem_write), 128'(e.wr));
        check({tag, "_read"}, 128'(pmem_read), 128'(!e.wr));
        check({tag, "_addr"}, 128'(pmem_address), 128'(e.addr));
        if (e.wr) check({tag, "_wdata"}, pmem_wdata, e.data);
        check({tag, "_no_early_resp"}, 128'(fill_resp), 128'(0));
        if (wb_at_resp) check({tag, "_wb_stall"}, 128'(wb_ack), 128'(0));
        @(negedge clk); #1;
        check({tag, "_addr_stable"}, 128'(pmem_address), 128'(e.addr));
        check({tag, "_dir_stable"}, 128'(pmem_write), 128'(e.wr));
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        #1;
        if (!e.wr) begin
            check({tag, "_fill_resp"}, 128'(fill_resp), 128'(1));
            check({tag, "_fill_sb_nonempty"}, 128'(exp_fill.size() != 0), 128'(1));
            ef = (exp_fill.size() != 0) ? exp_fill.pop_front() : 128'h0;
            check({tag, "_fill_data"}, fill_data, ef);
        end else begin
            check({tag, "_no_fill_resp"}, 128'(fill_resp), 128'(0));
        end
        if (wb_at_resp) check({tag, "_wb_ack_at_resp"}, 128'(wb_ack), 128'(1));
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        if (!e.wr) fill_req = 1'b0;
        if (wb_at_resp) wb_req = 1'b0;
        #1;
    endtask

    initial begin
        logic [127:0] d1, d2, d3, d4, d5, d6, m1, r4, m6, ef;
        d1 = {4{32'hD1D1_2340}};
        d2 = {16{8'hAA}};
        d3 = {4{32'hC0DE_4000}};
        d4 = {4{32'h4444_0000}};
        r4 = {4{32'h8888_8001}};
        d5 = {4{32'h5555_5000}};
        d6 = {4{32'h6666_4000}};
        m1 = {4{32'h1111_2340}};
        m6 = {4{32'h1357_9BDF}};

        rst = 1'b1; wb_req = 1'b0; wb_addr = '0; wb_data = '0;
        fill_req = 1'b0; fill_addr = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        #1;
        check("rst_pmem_read", 128'(pmem_read), 128'(0));
        check("rst_pmem_write", 128'(pmem_write), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_wb_ack", 128'(wb_ack), 128'(0));
        check("rst_fill_resp", 128'(fill_resp), 128'(0));
        check("rst_pmem_address", 128'(pmem_address), 128'(0));
        check("rst_pmem_wdata", pmem_wdata, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;

        // 1: reset in the middle of a drain discards the line
        evict(16'h2340, d1, "t1");
        @(negedge clk); #1;
        check("t1_drain_active", 128'(pmem_write), 128'(1));
        rst = 1'b1;
        #1;
        check("t1_rst_pmem_write", 128'(pmem_write), 128'(0));
        check("t1_rst_busy", 128'(busy), 128'(0));
        check("t1_rst_pmem_address", 128'(pmem_address), 128'(0));
        check("t1_rst_pmem_wdata", pmem_wdata, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        fill_req = 1'b1; fill_addr = 16'h2340;
        exp_pmem.push_back('{wr: 1'b0, addr: 16'h2340, data: 128'h0});
        exp_fill.push_back(m1);
        pmem_service(m1, "t1_fill", 1'b0);
        check("t1_idle_busy", 128'(busy), 128'(0));

        // 2: plain evict and drain
        exp_pmem.push_back('{wr: 1'b1, addr: 16'h1230, data: d2});
        evict(16'h1230, d2, "t2");
        pmem_service('0, "t2_drain", 1'b0);
        check("t2_busy_after", 128'(busy), 128'(0));

        // 3: refill hits the freshly captured line
        evict(16'h4000, d3, "t3");
        fill_req = 1'b1; fill_addr = 16'h4008;
        exp_fill.push_back(d3);
        exp_pmem.push_back('{wr: 1'b1, addr: 16'h4000, data: d3});
        #1;
        check("t3_resp_not_yet", 128'(fill_resp), 128'(0));
        @(negedge clk); #1;
        check("t3_hit_resp", 128'(fill_resp), 128'(1));
        ef = (exp_fill.size() != 0) ? exp_fill.pop_front() : 128'h0;
        check("t3_hit_data", fill_data, ef);
        check("t3_no_pmem_read", 128'(pmem_read), 128'(0));
        fill_req = 1'b0;
        @(negedge clk); #1;
        check("t3_single_pulse", 128'(fill_resp), 128'(0));
        pmem_service('0, "t3_drain", 1'b0);

        // 4: refill miss goes to memory before the drain
        evict(16'h4000, d4, "t4");
        fill_req = 1'b1; fill_addr = 16'h8000;
        exp_pmem.push_back('{wr: 1'b0, addr: 16'h8000, data: 128'h0});
        exp_fill.push_back(r4);
        exp_pmem.push_back('{wr: 1'b1, addr: 16'h4000, data: d4});
        pmem_service(r4, "t4_fill", 1'b0);
        pmem_service('0, "t4_drain", 1'b0);
        check("t4_busy_after", 128'(busy), 128'(0));

        // 5: second evict is accepted exactly in the drain-complete cycle
        evict(16'h4000, d3, "t5a");
        wb_req = 1'b1; wb_addr = 16'h5000; wb_data = d5;
        #1;
        check("t5_held_stall", 128'(wb_ack), 128'(0));
        exp_pmem.push_back('{wr: 1'b1, addr: 16'h4000, data: d3});
        exp_pmem.push_back('{wr: 1'b1, addr: 16'h5000, data: d5});
        pmem_service('0, "t5_drain_a", 1'b1);
        check("t5_busy_between", 128'(busy), 128'(1));
        pmem_service('0, "t5_drain_b", 1'b0);
        check("t5_busy_after", 128'(busy), 128'(0));

        // 6: refill matching the draining line waits, then misses
        evict(16'h4000, d6, "t6");
        @(negedge clk); #1;
        check("t6_drain_active", 128'(pmem_write), 128'(1));
        fill_req = 1'b1; fill_addr = 16'h4000;
        exp_pmem.push_back('{wr: 1'b1, addr: 16'h4000, data: d6});
        exp_pmem.push_back('{wr: 1'b0, addr: 16'h4000, data: 128'h0});
        exp_fill.push_back(m6);
        pmem_service('0, "t6_drain", 1'b0);
        pmem_service(m6, "t6_fill", 1'b0);
        check("t6_busy_after", 128'(busy), 128'(0));
        check("t6_sb_drained", 128'(exp_pmem.size() + exp_fill.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
